// File: rtl/branch_resolve_unit.sv
// Branch unit: 2-bit saturating BHT lookup on fetch, registered branch resolution on execute,
// and a fixed-length flush window after a mispredict. Define BRU_STATS_EN to add branch/mispredict counters.
module branch_resolve_unit #(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 16,
  parameter int BHT_DEPTH   = 16,
  parameter int RECOVER_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid,
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [1:0]        ex_op,
  input  logic              ex_unsigned,
  input  logic [DATA_W-1:0] ex_a,
  input  logic [DATA_W-1:0] ex_b,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_target,
  input  logic [PC_W-1:0]   ex_fallthru,
  output logic              rs_valid,
  output logic              rs_taken,
  output logic              rs_mispredict,
  output logic [PC_W-1:0]   rs_redirect_pc
`ifdef BRU_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int CNT_W = $clog2(RECOVER_CYC + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]       bht [BHT_DEPTH];

  // Condition evaluation: one subtractor provides borrow, sign and overflow.
  logic [DATA_W:0] diff;
  logic            eq, lt_u, lt_s, lt, taken, mispredict, accept;

  assign diff       = {1'b0, ex_a} - {1'b0, ex_b};
  assign eq         = (ex_a == ex_b);
  assign lt_u       = diff[DATA_W];
  assign lt_s       = diff[DATA_W-1] ^
                      ((ex_a[DATA_W-1] != ex_b[DATA_W-1]) & (diff[DATA_W-1] != ex_a[DATA_W-1]));
  assign lt         = ex_unsigned ? lt_u : lt_s;
  assign taken      = (ex_op[1] ? lt : eq) ^ ex_op[0];
  assign mispredict = taken ^ ex_pred_taken;
  assign accept     = ex_valid & ex_ready;

  logic [IDX_W-1:0] ex_idx, f_idx;
  logic [1:0]       cur_ctr, upd_ctr;
  logic             f_pred_d;

  assign ex_idx  = ex_pc[IDX_W-1:0];
  assign f_idx   = f_pc[IDX_W-1:0];
  assign cur_ctr = bht[ex_idx];

  always_comb begin
    upd_ctr = cur_ctr;
    if (taken) begin
      if (cur_ctr != 2'b11) upd_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) upd_ctr = cur_ctr - 2'd1;
    end
  end

  // A lookup hitting the entry written on this edge sees the post-update value.
  assign f_pred_d = (accept && (f_idx == ex_idx)) ? upd_ctr[1] : bht[f_idx][1];

  // NOTE: the BHT is a flop array, not a RAM, so it can and must be reset to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (accept) begin
      bht[ex_idx] <= upd_ctr;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pred_taken   <= 1'b0;
      rs_valid       <= 1'b0;
      rs_taken       <= 1'b0;
      rs_mispredict  <= 1'b0;
      rs_redirect_pc <= '0;
    end else begin
      if (f_valid) f_pred_taken <= f_pred_d;
      rs_valid <= accept;
      if (accept) begin
        rs_taken       <= taken;
        rs_mispredict  <= mispredict;
        rs_redirect_pc <= taken ? ex_target : ex_fallthru;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    ex_ready = 1'b0;
    case (state_q)
      RUN: begin
        ex_ready = 1'b1;
        if (ex_valid && mispredict) begin
          state_d = FLUSH;
          rcnt_d  = CNT_W'(RECOVER_CYC);
        end
      end
      FLUSH: begin
        rcnt_d = rcnt_q - CNT_W'(1);
        if (rcnt_q == CNT_W'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

`ifdef BRU_STATS_EN
  // Saturating event counters; a synchronous clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (stat_clr) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (accept && (stat_branches != '1)) stat_branches <= stat_branches + 32'd1;
      if (accept && mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit with default parameters (16-entry BHT, 2-cycle recovery).
// Define BRU_STATS_EN to also exercise the statistics counters.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic [15:0] f_pc;
  logic        f_pred_taken;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_op;
  logic        ex_unsigned;
  logic [15:0] ex_a, ex_b, ex_pc, ex_target, ex_fallthru;
  logic        ex_pred_taken;
  logic        rs_valid, rs_taken, rs_mispredict;
  logic [15:0] rs_redirect_pc;
`ifdef BRU_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] BEQ = 2'b00, BNE = 2'b01, BLT = 2'b10, BGE = 2'b11;

  branch_resolve_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_pred_taken   (f_pred_taken),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_op          (ex_op),
    .ex_unsigned    (ex_unsigned),
    .ex_a           (ex_a),
    .ex_b           (ex_b),
    .ex_pc          (ex_pc),
    .ex_pred_taken  (ex_pred_taken),
    .ex_target      (ex_target),
    .ex_fallthru    (ex_fallthru),
    .rs_valid       (rs_valid),
    .rs_taken       (rs_taken),
    .rs_mispredict  (rs_mispredict),
    .rs_redirect_pc (rs_redirect_pc)
`ifdef BRU_STATS_EN
    ,
    .stat_clr         (stat_clr),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [1:0] op, input logic uns, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] pc, input logic pred,
                        input logic [15:0] tgt, input logic [15:0] fall);
    ex_valid      = 1'b1;
    ex_op         = op;
    ex_unsigned   = uns;
    ex_a          = a;
    ex_b          = b;
    ex_pc         = pc;
    ex_pred_taken = pred;
    ex_target     = tgt;
    ex_fallthru   = fall;
  endtask

  initial begin
    rst_n = 1'b0;
    f_valid = 1'b0; f_pc = '0;
    ex_valid = 1'b0; ex_op = BEQ; ex_unsigned = 1'b0;
    ex_a = '0; ex_b = '0; ex_pc = '0; ex_pred_taken = 1'b0; ex_target = '0; ex_fallthru = '0;
`ifdef BRU_STATS_EN
    stat_clr = 1'b0;
`endif
    tick();
    tick();
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_rs_valid", 32'(rs_valid), 32'd0);
    check("rst_redirect", 32'(rs_redirect_pc), 32'h0);
    rst_n = 1'b1;

    // Fetch lookup of an untouched entry: weakly not-taken.
    f_valid = 1'b1; f_pc = 16'h0005;
    tick();
    f_valid = 1'b0;
    check("fetch_reset_pred", 32'(f_pred_taken), 32'd0);
    check("idle_rs_valid", 32'(rs_valid), 32'd0);

    // Signed BLT: -32768 < 1, predicted not-taken -> mispredict and flush.
    branch(BLT, 1'b0, 16'h8000, 16'h0001, 16'h0010, 1'b0, 16'h0100, 16'h0014);
    tick();
    check("blts_valid", 32'(rs_valid), 32'd1);
    check("blts_taken", 32'(rs_taken), 32'd1);
    check("blts_misp", 32'(rs_mispredict), 32'd1);
    check("blts_redirect", 32'(rs_redirect_pc), 32'h0100);
    check("flush_ready_1", 32'(ex_ready), 32'd0);
    branch(BEQ, 1'b0, 16'h0001, 16'h0001, 16'h0020, 1'b0, 16'h0200, 16'h0024);
    tick();
    check("flush_ready_2", 32'(ex_ready), 32'd0);
    check("flush_rs_valid", 32'(rs_valid), 32'd0);
    tick();
    check("flush_done_ready", 32'(ex_ready), 32'd1);
    ex_valid = 1'b0;
    f_valid = 1'b1; f_pc = 16'h0000;
    tick();
    f_valid = 1'b0;
    check("flush_ignored_valid", 32'(rs_valid), 32'd0);
    check("flush_redirect_held", 32'(rs_redirect_pc), 32'h0100);
    check("bht0_after_taken", 32'(f_pred_taken), 32'd1);

    // Unsigned BLT: 0x8000 < 1 is false -> correctly predicted not-taken, no flush.
    branch(BLT, 1'b1, 16'h8000, 16'h0001, 16'h0021, 1'b0, 16'h0300, 16'h0025);
    tick();
    ex_valid = 1'b0;
    check("bltu_valid", 32'(rs_valid), 32'd1);
    check("bltu_taken", 32'(rs_taken), 32'd0);
    check("bltu_misp", 32'(rs_mispredict), 32'd0);
    check("bltu_redirect", 32'(rs_redirect_pc), 32'h0025);
    check("bltu_ready", 32'(ex_ready), 32'd1);

    // Three taken BEQ at pc 3 with forwarded lookups of 0x13 (same index): 01->10->11->11.
    branch(BEQ, 1'b0, 16'h1234, 16'h1234, 16'h0003, 1'b1, 16'h0400, 16'h0007);
    f_valid = 1'b1; f_pc = 16'h0013;
    tick();
    check("beq1_fwd_pred", 32'(f_pred_taken), 32'd1);
    check("beq1_taken", 32'(rs_taken), 32'd1);
    check("beq1_ready", 32'(ex_ready), 32'd1);
    tick();
    check("beq2_valid", 32'(rs_valid), 32'd1);
    check("beq2_pred", 32'(f_pred_taken), 32'd1);
    tick();
    check("beq3_valid", 32'(rs_valid), 32'd1);
    check("beq3_misp", 32'(rs_mispredict), 32'd0);
    // One not-taken update from a saturated 11 gives 10, still predicting taken.
    branch(BNE, 1'b0, 16'h1234, 16'h1234, 16'h0003, 1'b0, 16'h0400, 16'h0007);
    f_pc = 16'h0003;
    tick();
    ex_valid = 1'b0; f_valid = 1'b0;
    check("sat_bne_taken", 32'(rs_taken), 32'd0);
    check("sat_fwd_pred", 32'(f_pred_taken), 32'd1);

    // Back-to-back correctly predicted BNE (not taken) and signed BGE (taken).
    branch(BNE, 1'b0, 16'h7FFF, 16'h7FFF, 16'h0030, 1'b0, 16'h0500, 16'h0034);
    tick();
    check("b2b1_valid", 32'(rs_valid), 32'd1);
    check("b2b1_taken", 32'(rs_taken), 32'd0);
    check("b2b1_ready", 32'(ex_ready), 32'd1);
    branch(BGE, 1'b0, 16'h7FFF, 16'h8000, 16'h0031, 1'b1, 16'h0600, 16'h0035);
    tick();
    ex_valid = 1'b0;
    check("b2b2_valid", 32'(rs_valid), 32'd1);
    check("b2b2_taken", 32'(rs_taken), 32'd1);
    check("b2b2_redirect", 32'(rs_redirect_pc), 32'h0600);
    check("b2b2_ready", 32'(ex_ready), 32'd1);
    tick();
    check("idle_valid_drop", 32'(rs_valid), 32'd0);
    check("idle_taken_held", 32'(rs_taken), 32'd1);

    // Mispredict at pc 5, then asynchronous reset in the middle of the flush.
    branch(BEQ, 1'b0, 16'h0042, 16'h0042, 16'h0005, 1'b0, 16'h0700, 16'h0009);
    tick();
    ex_valid = 1'b0;
    check("pre_rst_ready", 32'(ex_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midflush_rst_ready", 32'(ex_ready), 32'd1);
    check("midflush_rst_valid", 32'(rs_valid), 32'd0);
    check("midflush_rst_redirect", 32'(rs_redirect_pc), 32'h0);
    rst_n = 1'b1;
    f_valid = 1'b1; f_pc = 16'h0003;
    tick();
    check("bht3_reset_pred", 32'(f_pred_taken), 32'd0);
    f_pc = 16'h0000;
    tick();
    check("bht0_reset_pred", 32'(f_pred_taken), 32'd0);
    f_valid = 1'b0;
    check("post_rst_ready", 32'(ex_ready), 32'd1);

`ifdef BRU_STATS_EN
    check("stat_rst_br", stat_branches, 32'd0);
    branch(BEQ, 1'b0, 16'h0001, 16'h0001, 16'h0007, 1'b1, 16'h0800, 16'h000B);
    tick();
    branch(BNE, 1'b0, 16'h0001, 16'h0002, 16'h0007, 1'b1, 16'h0800, 16'h000B);
    tick();
    branch(BLT, 1'b1, 16'h0001, 16'h0002, 16'h0007, 1'b1, 16'h0800, 16'h000B);
    tick();
    branch(BEQ, 1'b0, 16'h0001, 16'h0002, 16'h0007, 1'b1, 16'h0800, 16'h000B);
    tick();
    ex_valid = 1'b0;
    check("stat_branches", stat_branches, 32'd4);
    check("stat_mispredicts", stat_mispredicts, 32'd1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stat_clr_br", stat_branches, 32'd0);
    check("stat_clr_misp", stat_mispredicts, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised branch unit for the SCRISC core. It combines a branch history table (BHT) with registered branch resolution.
- Fetch side: looks up a 2-bit saturating predictor per PC and returns a predicted direction.
- Execute side: evaluates BEQ/BNE/BLT/BGE (signed or unsigned) on full operands, flags mispredicts, updates the BHT, and holds execute off for a fixed recovery window while the pipeline flushes.

Parameters:
- DATA_W, 16, operand width in bits (>=2).
- PC_W, 16, program-counter width.
- BHT_DEPTH, 16, number of predictor entries; power of 2, >=2. IDX_W = log2(BHT_DEPTH).
- RECOVER_CYC, 2, cycles ex_ready is held low after a mispredict (>=1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- f_valid  in  1  fetch lookup request.
- f_pc  in  PC_W  fetch PC.
- f_pred_taken  out  1  prediction for the previous cycle's f_pc.
- ex_valid  in  1  branch presented for resolution.
- ex_ready  out  1  unit accepts a branch this cycle.
- ex_op  in  2  00 BEQ, 01 BNE, 10 BLT, 11 BGE; bit0 inverts the condition.
- ex_unsigned  in  1  1 = unsigned compare for BLT/BGE.
- ex_a, ex_b  in  DATA_W  compare operands.
- ex_pc  in  PC_W  PC of the branch (BHT index).
- ex_pred_taken  in  1  prediction carried down the pipe with the branch.
- ex_target  in  PC_W  taken target.
- ex_fallthru  in  PC_W  not-taken PC.
- rs_valid  out  1  resolution result valid (one-cycle pulse).
- rs_taken  out  1  actual direction.
- rs_mispredict  out  1  actual direction differs from ex_pred_taken.
- rs_redirect_pc  out  PC_W  correct next PC (target if taken, else fallthru).

Behaviour:
- Reset (async, rst_n=0): all BHT entries = 2'b01 (weakly not-taken); f_pred_taken=0; rs_valid=0; rs_taken=0; rs_mispredict=0; rs_redirect_pc=0; FSM=RUN; ex_ready=1; recovery counter=0. Reset mid-flush abandons the flush immediately.
- BHT index = pc[IDX_W-1:0].
- Fetch lookup:
  - f_valid=1 in cycle M gives f_pred_taken = counter[1] in cycle M+1.
  - f_valid=0 holds f_pred_taken.
- Condition evaluation is done on the full DATA_W operands:
  - eq = (a==b).
  - Unsigned lt = borrow out of a-b.
  - Signed lt = sign(a-b) XOR overflow, where overflow = (a[msb]!=b[msb]) & (diff[msb]!=a[msb]).
  - cond = ex_op[1] ? lt : eq; taken = cond ^ ex_op[0].
- Accept: a branch is accepted when ex_valid & ex_ready in cycle N. In cycle N+1:
  - rs_valid=1.
  - rs_taken and rs_redirect_pc are driven for that branch.
  - rs_mispredict = taken ^ ex_pred_taken.
  - Outputs are registered: latency exactly 1.
- rs_valid=0 in any cycle following a non-accept. Other rs_* outputs hold their last values.
- BHT update: written at the end of cycle N, i.e. the same edge that registers rs_*. Counter increments on taken (saturates at 11) and decrements on not-taken (saturates at 00).
- Same-index collision: if f_valid in cycle N hits the index being updated, f_pred_taken in N+1 reflects the post-update counter (forwarded).
- FSM:
  - RUN: ex_ready=1. An accepted mispredict moves to FLUSH with recovery counter = RECOVER_CYC.
  - FLUSH: ex_ready=0; ex_valid is ignored and the BHT is not updated; fetch lookups continue. The counter decrements each cycle; the FSM returns to RUN in the cycle the counter reaches 0. ex_ready therefore is low in cycles N+1 .. N+RECOVER_CYC.
- Back-to-back correct predictions resolve every cycle with no bubble.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined: adds input stat_clr (1) and outputs stat_branches (32) and stat_mispredicts (32).
  - Counters increment on each accepted branch / each mispredict and saturate at all-ones.
  - Both are cleared synchronously by stat_clr (clear wins over an increment in the same cycle) and asynchronously by rst_n.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then f_valid with f_pc=0x0005 -> f_pred_taken=0 next cycle; ex_ready=1; rs_valid=0.
- BLT signed, a=0x8000, b=0x0001, ex_pred_taken=0 -> next cycle rs_taken=1, rs_mispredict=1, rs_redirect_pc=ex_target. ex_ready low for exactly 2 cycles; an ex_valid asserted during them is not resolved.
- BLT unsigned, same operands, ex_pred_taken=0 -> rs_taken=0, rs_mispredict=0, rs_redirect_pc=ex_fallthru; no flush.
- Three taken BEQ (a=b=0x1234) at pc=0x0003 -> counter goes 01->10->11->11. Fetch of 0x0013 issued in the cycle of the first update sees f_pred_taken=1 (forwarded, same index for DEPTH 16).
- BNE, a=0x7FFF, b=0x7FFF, then BGE signed, a=0x7FFF, b=0x8000, issued back-to-back with correct predictions -> rs_taken 0 then 1, rs_valid two consecutive cycles, ex_ready stays 1.
- rst_n pulsed low during FLUSH -> ex_ready=1 and all BHT entries=01 immediately. With BRU_STATS_EN: after 4 branches with 1 mispredict, stat_branches=4 and stat_mispredicts=1; stat_clr sets both to 0.
